tmc_reg_seq: RTL

Register-access sequencer feeding the 40-bit stepper-driver SPI master. It takes single register read/write requests, builds 40-bit driver datagrams (write flag, 7-bit address, 32-bit data) and triggers the SPI transfer. It also handles the driver's pipelined read semantics, where read data returns on the following frame, and returns status byte, data and a timeout flag to the requester. It sits between the motion/config control logic in `top` and the `spi` instance.

---
 rtl/tmc_reg_seq_pkg.sv | 27 ++
 rtl/tmc_reg_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tmc_reg_seq_pkg.sv
// rtl/tmc_reg_seq_pkg.sv - datagram layout, FSM states and frame builder for tmc_reg_seq
package tmc_reg_seq_pkg;

  localparam int FRAME_W   = 40;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int WRITE_BIT = 39;
  localparam int STATUS_HI = 39;
  localparam int STATUS_LO = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_RESP,
    ST_RESP_GAP
  } state_t;

  // Reads carry a zero payload; the driver ignores it but keeps the bus deterministic.
  function automatic logic [FRAME_W-1:0] build_frame(input logic              wr,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {wr, addr, (wr ? data : {DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/tmc_reg_seq.sv
// rtl/tmc_reg_seq.sv - register read/write sequencer building 40-bit driver datagrams for the SPI master
module tmc_reg_seq
  import tmc_reg_seq_pkg::*;
#(
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               req_valid_in,
  output logic               req_ready_out,
  input  logic               req_write_in,
  input  logic [ADDR_W-1:0]  req_addr_in,
  input  logic [DATA_W-1:0]  req_data_in,
  output logic               rsp_valid_out,
  output logic [7:0]         rsp_status_out,
  output logic [DATA_W-1:0]  rsp_data_out,
  output logic               rsp_timeout_out,
  output logic [FRAME_W-1:0] spi_data_out,
  output logic               spi_send_out,
  input  logic [FRAME_W-1:0] spi_data_in,
  input  logic               spi_done_in
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  // The RESP cycle itself counts as the first post-response idle cycle.
  localparam logic [CNT_W-1:0] RGAP_LOAD = CNT_W'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               frame_idx;
  logic [FRAME_W-1:0] rx_q;

  logic accept, capture, idx_set, rsp_load, rsp_to;

  assign req_ready_out = (state == ST_IDLE) && !rst_in;
  assign spi_send_out  = (state == ST_SEND);
  assign rsp_valid_out = (state == ST_RESP);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
    accept    = 1'b0;
    capture   = 1'b0;
    idx_set   = 1'b0;
    rsp_load  = 1'b0;
    rsp_to    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid_in) begin
          accept    = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = TO_LOAD;
      end
      ST_WAIT: begin
        // A completion on the last allowed cycle still wins over the timeout.
        if (spi_done_in) begin
          capture   = 1'b1;
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end else if (cnt == '0) begin
          rsp_load  = 1'b1;
          rsp_to    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          // Reads are pipelined in the driver: resend the same datagram to fetch the data.
          if (!spi_data_out[WRITE_BIT] && !frame_idx) begin
            idx_set   = 1'b1;
            state_nxt = ST_SEND;
          end else begin
            rsp_load  = 1'b1;
            state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (GAP_CYCLES > 1) begin
          state_nxt = ST_RESP_GAP;
          cnt_nxt   = RGAP_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP_GAP: begin
        if (cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt             <= '0;
      frame_idx       <= 1'b0;
      rx_q            <= '0;
      spi_data_out    <= '0;
      rsp_status_out  <= '0;
      rsp_data_out    <= '0;
      rsp_timeout_out <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (accept) begin
        spi_data_out <= build_frame(req_write_in, req_addr_in, req_data_in);
        frame_idx    <= 1'b0;
      end
      if (idx_set) frame_idx <= 1'b1;
      if (capture) rx_q <= spi_data_in;
      if (rsp_load) begin
        rsp_timeout_out <= rsp_to;
        rsp_status_out  <= rsp_to ? 8'h00 : rx_q[STATUS_HI:STATUS_LO];
        rsp_data_out    <= rsp_to ? {DATA_W{1'b0}} : rx_q[DATA_W-1:0];
      end
    end
  end

endmodule
